// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity check scheduler: FSM state encoding,
// nibble width and the odd-parity error function.
package parity_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Odd parity: an odd count of ones across {nibble, par} is good, even is an error.
  function automatic logic odd_par_err(input logic [NIBBLE_W:0] bits);
    return ~(^bits);
  endfunction

endpackage

// File: rtl/parity_check_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod NREQ) and
// returns the first requester found, one-hot and encoded.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    pick;
  logic              found;

  // Rotate so that bit 0 of req_rot is requester ptr+1; the first set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> (int'(ptr) + 1));

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        pick  = IDW'((int'(ptr) + 1 + j) % NREQ);
      end
    end
  end

  assign idx = pick;
  assign any = found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign gnt[gi] = en & found & (pick == IDW'(gi));
  end

endmodule

// File: rtl/parity_check_scheduler.sv
// Time-shares one 4-bit odd-parity checker among NREQ requesters with round-robin
// grant, a three-state accept/check/respond FSM and a saturating error counter.
module parity_check_scheduler
  import parity_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NIBBLE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]            req_par,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic                       rsp_err,
  input  logic                       rsp_ready,
  input  logic                       clr_count,
  output logic [CNTW-1:0]            err_count,
  output logic                       busy
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t                state_reg, state_next;
  logic [IDW-1:0]        ptr_reg;
  logic [NIBBLE_W-1:0]   op_data_reg;
  logic                  op_par_reg;
  logic [IDW-1:0]        op_id_reg;
  logic                  err_reg;
  logic [CNTW-1:0]       err_count_reg;

  logic [NIBBLE_W-1:0]   nib [NREQ];
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;
  logic                  arb_en;
  logic                  accept;
  logic                  rsp_fire;
  logic [NIBBLE_W-1:0]   sel_data;
  logic                  sel_par;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_nib
    assign nib[gi] = req_data[NIBBLE_W*gi +: NIBBLE_W];
  end

  // Grants are gated by rst_n so req_ready reads 0 while reset is held.
  assign arb_en = (state_reg == IDLE) && rst_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_reg),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;
  assign accept    = arb_en & gnt_any;
  assign rsp_fire  = (state_reg == RESP) & rsp_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = nib[i];
    end
  end

  assign sel_par = |(req_par & gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CHECK;
      CHECK:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= IDW'(NREQ - 1);
      op_data_reg <= '0;
      op_par_reg  <= 1'b0;
      op_id_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        op_data_reg <= sel_data;
        op_par_reg  <= sel_par;
        op_id_reg   <= gnt_idx;
      end
      if (state_reg == CHECK) err_reg <= odd_par_err({op_data_reg, op_par_reg});
      if (rsp_fire) ptr_reg <= op_id_reg;
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           err_count_reg <= '0;
    else if (clr_count)                                   err_count_reg <= '0;
    else if (rsp_fire && err_reg && err_count_reg != CNT_MAX) err_count_reg <= err_count_reg + 1'b1;
  end

  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = op_id_reg;
  assign rsp_err   = err_reg;
  assign err_count = err_count_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Directed bench for parity_check_scheduler: handshake timing, parity rule,
// round-robin order, backpressure, counter saturation/clear and mid-flight reset.
module tb_parity_check_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_par;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        rsp_ready;
  logic        clr_count;
  logic [7:0]  err_count;
  logic        busy;

  logic [3:0]  req_ready2;
  logic        rsp_valid2;
  logic [1:0]  rsp_id2;
  logic        rsp_err2;
  logic [1:0]  err_count2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_check_scheduler #(.NREQ(4), .IDW(2), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_par(req_par), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .clr_count(clr_count), .err_count(err_count), .busy(busy)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation checks.
  parity_check_scheduler #(.NREQ(4), .IDW(2), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_par(req_par), .req_ready(req_ready2), .rsp_valid(rsp_valid2),
    .rsp_id(rsp_id2), .rsp_err(rsp_err2), .rsp_ready(rsp_ready),
    .clr_count(clr_count), .err_count(err_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_id"},    32'(rsp_id),    32'd0);
    check({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, ".err_count"}, 32'(err_count), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // One full request/response from IDLE; returns in IDLE just after the handshake.
  task automatic run_one(input string tag, input logic [3:0] valid, input logic [15:0] data,
                         input logic [3:0] par, input int exp_id, input logic exp_err,
                         input logic clr);
    logic [3:0] exp_rdy;
    exp_rdy   = 4'b0001 << exp_id;
    req_valid = valid;
    req_data  = data;
    req_par   = par;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    req_valid = 4'b0000;
    check({tag, ".chk_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_id"},    32'(rsp_id),    32'(exp_id));
    check({tag, ".rsp_err"},   32'(rsp_err),   32'(exp_err));
    rsp_ready = 1'b1;
    clr_count = clr;
    tick();
    rsp_ready = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] exp_ids [5];
    logic       exp_errs [5];
    exp_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_errs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    req_par   = '0;
    rsp_ready = 1'b0;
    clr_count = 1'b0;
    tick();
    check_idle_outputs("reset");
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    #1;

    // 1: good nibble from requester 0
    run_one("t1", 4'b0001, 16'h000A, 4'b0001, 0, 1'b0, 1'b0);
    check("t1.count", 32'(err_count), 32'd0);

    // 2: parity rule
    run_one("t2a", 4'b0001, 16'h000A, 4'b0000, 0, 1'b1, 1'b0);
    check("t2a.count", 32'(err_count), 32'd1);
    run_one("t2b", 4'b0001, 16'h0000, 4'b0001, 0, 1'b0, 1'b0);
    run_one("t2c", 4'b0001, 16'h000F, 4'b0000, 0, 1'b1, 1'b0);
    check("t2c.count", 32'(err_count), 32'd2);

    // 3: round-robin with all valids held and rsp_ready high
    do_reset();
    req_data  = 16'h713A;
    req_par   = 4'b1001;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t3.ready%0d", k), 32'(req_ready), 32'(4'b0001 << exp_ids[k]));
      tick();
      tick();
      check($sformatf("t3.valid%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("t3.id%0d", k),    32'(rsp_id),    32'(exp_ids[k]));
      check($sformatf("t3.err%0d", k),   32'(rsp_err),   32'(exp_errs[k]));
      tick();
    end
    check("t3.count", 32'(err_count), 32'd2);

    // 4: backpressure in RESP
    req_valid = 4'b0100;
    req_data  = 16'h0C00;
    req_par   = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    check("t4.ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4.valid%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("t4.id%0d", k),    32'(rsp_id),    32'd2);
      check($sformatf("t4.err%0d", k),   32'(rsp_err),   32'd1);
      check($sformatf("t4.rdy%0d", k),   32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4.after_valid", 32'(rsp_valid), 32'd0);
    check("t4.after_busy",  32'(busy),      32'd0);
    tick();
    check("t4.no_second",   32'(rsp_valid), 32'd0);
    check("t4.count",       32'(err_count), 32'd3);

    // 5: saturation on the 2-bit counter, then clear against an error handshake
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_one($sformatf("t5.e%0d", k), 4'b0001, 16'h000A, 4'b0000, 0, 1'b1, 1'b0);
      check($sformatf("t5.cnt2_%0d", k), 32'(err_count2), 32'(k == 3 ? 3 : k + 1));
      check($sformatf("t5.cnt8_%0d", k), 32'(err_count),  32'(k + 1));
    end
    run_one("t5.clr", 4'b0001, 16'h000A, 4'b0000, 0, 1'b1, 1'b1);
    check("t5.clr_cnt2", 32'(err_count2), 32'd0);
    check("t5.clr_cnt8", 32'(err_count),  32'd0);

    // 6: reset during CHECK
    req_valid = 4'b0100;
    req_data  = 16'h050A;
    req_par   = 4'b0000;
    tick();
    req_valid = 4'b0000;
    check("t6.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_valid = 4'b0111;
    #1;
    check_idle_outputs("t6.rst");
    tick();
    tick();
    check("t6.rst_hold_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
    check("t6.no_rsp", 32'(rsp_valid), 32'd0);
    run_one("t6.prio", 4'b0111, 16'h050A, 4'b0000, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
